icache_ctrl: RTL and testbench
==============================

# icache_ctrl

Direct-mapped, read-only cache controller that owns the write side of the cache's valid-bit RAM (1024 × 1), tag RAM and data RAM. It drives index, write strobe and write data to those arrays and consumes their registered read outputs. It services CPU fetch requests, fills lines from memory on a miss, and sweeps all valid bits to 0 on a flush command. It sits between the CPU fetch stage and the memory interface.

## Interface
- CACHESIZE, 1024: number of lines; index width is fixed at 10 bits.
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  fetch request; held with cpu_addr until cpu_ack.
- cpu_addr  in  32  byte address: tag = [31:12], index = [11:2], offset [1:0] ignored.
- cpu_ack  out  1  one-cycle pulse; cpu_rdata is valid in this cycle.
- cpu_rdata  out  32  fetched word (registered).
- flush  in  1  pulse; requests invalidation of all lines.
- flush_done  out  1  one-cycle pulse when the sweep completes.
- vr_index  out  10  index to the valid, tag and data arrays.
- vr_write  out  1  write strobe to all three arrays.
- vr_v_in  out  1  valid bit to write.
- vr_v_out  in  1  registered valid read (value at the index presented at the previous edge).
- tag_in / tag_out  out/in  20  tag write data / registered tag read.
- data_in / data_out  out/in  32  line write data / registered data read.
- mem_req  out  1  memory read request (registered); held until mem_ready.
- mem_addr  out  32  word-aligned address {addr[31:2], 2'b00}.
- mem_ready  in  1  memory read data valid; completes the request.
- mem_rdata  in  32  memory read data.

## Operation
- FSM states: IDLE, COMPARE, MISS, FILL, FLUSH.
- IDLE:
  - vr_index = cpu_addr[11:2] (combinational).
  - flush (pending or current) has priority: go to FLUSH with counter = 0.
  - Otherwise, cpu_req high: latch cpu_addr and go to COMPARE.
- COMPARE:
  - vr_index = latched index. The array outputs are valid in this state.
  - hit = vr_v_out && (tag_out == latched tag).
  - On a hit: cpu_rdata <= data_out, cpu_ack <= 1, go to IDLE.
  - On a miss: mem_req <= 1, mem_addr <= {latched[31:2], 2'b00}, go to MISS.
- MISS:
  - Hold mem_req and mem_addr.
  - At an edge with mem_ready = 1: mem_req <= 0, capture mem_rdata, go to FILL.
- FILL:
  - vr_write = 1, vr_v_in = 1, tag_in = latched tag, data_in = captured word, vr_index = latched index.
  - At the edge: cpu_ack <= 1, cpu_rdata <= captured word, go to IDLE.
- FLUSH:
  - vr_write = 1, vr_v_in = 0, vr_index = counter. Counter increments each cycle.
  - After index 1023 is written: flush_done <= 1, go to IDLE.
  - tag_in and data_in are don't-care; the tag and data arrays must ignore writes, or accept the don't-care values harmlessly.
- vr_write is 0 in all states other than FILL and FLUSH.
- A flush arriving outside IDLE sets a pending flag. The flag is serviced on the next IDLE, before any cpu_req, and is cleared on entry to FLUSH.
- cpu_req held high in the cycle cpu_ack is high is a new request, accepted in that IDLE cycle.
- Reset (asynchronous, any state):
  - state = IDLE, counter = 0, pending flush cleared.
  - cpu_ack, cpu_rdata, mem_req, mem_addr and flush_done all go to 0.
  - An outstanding memory request is abandoned. Any mem_ready arriving later is ignored in IDLE.

## Timing
- Hit: cpu_req sampled in IDLE at edge E0 -> cpu_ack high in the cycle after edge E1 (2 cycles). Back-to-back hits: one per 2 cycles.
- Miss: mem_req rises in the cycle after E1. If mem_ready is sampled at edge Em, FILL is the cycle after Em and cpu_ack is in the cycle after that.
- Minimum miss latency, with mem_ready already high: 4 cycles from acceptance to cpu_ack.
- Flush: 1024 FLUSH cycles; flush_done occurs 1 cycle after the last write. Total 1025 cycles from entering FLUSH.
- Arrays are written at the edge that ends FILL or FLUSH. A same-index read presented at that edge returns the new value.

## Test plan
- Reset, then flush; wait for flush_done (1025 cycles). Fetch 0x0000_1004 -> miss: mem_req with mem_addr = 0x0000_1004. Return mem_rdata = 0xDEAD_BEEF with mem_ready -> cpu_ack with 0xDEAD_BEEF.
- Refetch 0x0000_1004 -> hit: cpu_ack 2 cycles after acceptance, cpu_rdata = 0xDEAD_BEEF, mem_req stays 0.
- Fetch 0x0000_2004 (same index 1, different tag) -> miss, fill 0x1234_5678. Then 0x0000_1004 -> miss again (tag evicted).
- Fill index 5, then flush -> vr_write/vr_v_in = 0 at every index 0..1023. Then fetch index 5 -> miss.
- Assert flush while in MISS -> the fill completes and is acked, then FLUSH starts before a cpu_req that is already pending.
- Assert reset during MISS with mem_req high -> mem_req, cpu_ack and state clear immediately. A late mem_ready produces no cpu_ack and no array write.

Source files
------------

// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
//   Direct-mapped, read-only instruction cache controller. Owns the write side
//   of the valid-bit, tag and data arrays (CACHESIZE lines, one 32-bit word per
//   line) and consumes their registered read outputs. Services CPU fetches,
//   fills a line from memory on a miss and sweeps every valid bit to 0 on flush.
//
// Ports
//   clock, reset          single clock; asynchronous active-high reset
//   cpu_req, cpu_addr     fetch request, held with its address until cpu_ack
//   cpu_ack, cpu_rdata    one-cycle acknowledge with the fetched word
//   flush, flush_done     invalidate-all request / one-cycle completion pulse
//   vr_index, vr_write    shared index and write strobe for the three arrays
//   vr_v_in, vr_v_out     valid bit write data / registered read
//   tag_in, tag_out       tag write data / registered read
//   data_in, data_out     line write data / registered read
//   mem_req, mem_addr     memory read request (held until mem_ready)
//   mem_ready, mem_rdata  memory read completion and data
// -----------------------------------------------------------------------------
module icache_ctrl #(
    parameter int CACHESIZE = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        flush,
    output logic        flush_done,
    output logic [9:0]  vr_index,
    output logic        vr_write,
    output logic        vr_v_in,
    input  logic        vr_v_out,
    output logic [19:0] tag_in,
    input  logic [19:0] tag_out,
    output logic [31:0] data_in,
    input  logic [31:0] data_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [9:0] LAST_INDEX = 10'(CACHESIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        MISS,
        FILL,
        FLUSH
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;          // latched fetch address
    logic [31:0] word_reg, word_next;          // word captured from memory
    logic [9:0]  counter_reg, counter_next;    // flush sweep index
    logic        pending_reg, pending_next;    // flush seen outside IDLE
    logic        cpu_ack_reg, cpu_ack_next;
    logic [31:0] cpu_rdata_reg, cpu_rdata_next;
    logic        mem_req_reg, mem_req_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic        flush_done_reg, flush_done_next;

    logic [19:0] addr_tag;
    logic [9:0]  addr_index;
    logic        hit;

    assign addr_tag   = addr_reg[31:12];
    assign addr_index = addr_reg[11:2];
    assign hit        = vr_v_out && (tag_out == addr_tag);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            word_reg       <= '0;
            counter_reg    <= '0;
            pending_reg    <= 1'b0;
            cpu_ack_reg    <= 1'b0;
            cpu_rdata_reg  <= '0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            flush_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            word_reg       <= word_next;
            counter_reg    <= counter_next;
            pending_reg    <= pending_next;
            cpu_ack_reg    <= cpu_ack_next;
            cpu_rdata_reg  <= cpu_rdata_next;
            mem_req_reg    <= mem_req_next;
            mem_addr_reg   <= mem_addr_next;
            flush_done_reg <= flush_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        word_next       = word_reg;
        counter_next    = counter_reg;
        // A flush outside IDLE is remembered until the next IDLE services it.
        pending_next    = pending_reg | (flush && (state_reg != IDLE));
        cpu_ack_next    = 1'b0;
        cpu_rdata_next  = cpu_rdata_reg;
        mem_req_next    = mem_req_reg;
        mem_addr_next   = mem_addr_reg;
        flush_done_next = 1'b0;

        vr_index = addr_index;
        vr_write = 1'b0;
        vr_v_in  = 1'b0;
        tag_in   = addr_tag;
        data_in  = word_reg;

        case (state_reg)
            IDLE: begin
                // Present the incoming index now so the arrays' registered
                // outputs are ready in COMPARE.
                vr_index = cpu_addr[11:2];
                if (flush || pending_reg) begin
                    state_next   = FLUSH;
                    counter_next = '0;
                    pending_next = 1'b0;
                end else if (cpu_req) begin
                    addr_next  = cpu_addr;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    cpu_rdata_next = data_out;
                    cpu_ack_next   = 1'b1;
                    state_next     = IDLE;
                end else begin
                    mem_req_next  = 1'b1;
                    // Offset bits are masked off for the word-aligned request.
                    mem_addr_next = {addr_reg[31:2], addr_reg[1:0] & 2'b00};
                    state_next    = MISS;
                end
            end
            MISS: begin
                if (mem_ready) begin
                    mem_req_next = 1'b0;
                    word_next    = mem_rdata;
                    state_next   = FILL;
                end
            end
            FILL: begin
                vr_write       = 1'b1;
                vr_v_in        = 1'b1;
                cpu_ack_next   = 1'b1;
                cpu_rdata_next = word_reg;
                state_next     = IDLE;
            end
            FLUSH: begin
                // tag_in/data_in carry stale values here; only the cleared
                // valid bit matters for a flushed line.
                vr_write     = 1'b1;
                vr_v_in      = 1'b0;
                vr_index     = counter_reg;
                counter_next = counter_reg + 10'd1;
                if (counter_reg == LAST_INDEX) begin
                    flush_done_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cpu_ack    = cpu_ack_reg;
    assign cpu_rdata  = cpu_rdata_reg;
    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;
    assign flush_done = flush_done_reg;

endmodule

// File: tb/tb_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_ctrl
//   Directed testbench for icache_ctrl. Models the three cache arrays with
//   registered, write-first reads and a simple memory responder driven from
//   the test tasks. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_icache_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        flush;
    logic        flush_done;
    logic [9:0]  vr_index;
    logic        vr_write;
    logic        vr_v_in;
    logic        vr_v_out;
    logic [19:0] tag_in;
    logic [19:0] tag_out;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    // array model + monitors
    logic        arr_preset = 1'b0;
    logic        valid_mem [1024];
    logic [19:0] tag_mem   [1024];
    logic [31:0] data_mem  [1024];
    int          fill_writes   = 0;
    int          clr_writes    = 0;
    int          clr_order_bad = 0;
    int          ack_count     = 0;
    logic [9:0]  clr_next_idx  = '0;

    always #5 clock = ~clock;

    icache_ctrl #(.CACHESIZE(1024)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .flush(flush), .flush_done(flush_done),
        .vr_index(vr_index), .vr_write(vr_write),
        .vr_v_in(vr_v_in), .vr_v_out(vr_v_out),
        .tag_in(tag_in), .tag_out(tag_out),
        .data_in(data_in), .data_out(data_out),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Preset makes every line look valid with tag 1, so a broken flush turns
    // the first fetch of 0x1004 into a false hit.
    always @(posedge clock) begin
        if (arr_preset) begin
            for (int i = 0; i < 1024; i++) begin
                valid_mem[i] <= 1'b1;
                tag_mem[i]   <= 20'h00001;
                data_mem[i]  <= 32'hBAD0_0BAD;
            end
        end else if (vr_write) begin
            valid_mem[vr_index] <= vr_v_in;
            tag_mem[vr_index]   <= tag_in;
            data_mem[vr_index]  <= data_in;
        end
        vr_v_out <= vr_write ? vr_v_in : valid_mem[vr_index];
        tag_out  <= vr_write ? tag_in  : tag_mem[vr_index];
        data_out <= vr_write ? data_in : data_mem[vr_index];
    end

    always @(posedge clock) begin
        if (cpu_ack) ack_count <= ack_count + 1;
        if (vr_write && vr_v_in) fill_writes <= fill_writes + 1;
        if (vr_write && !vr_v_in) begin
            clr_writes <= clr_writes + 1;
            if (vr_index != clr_next_idx) clr_order_bad <= clr_order_bad + 1;
            clr_next_idx <= 10'(vr_index + 10'd1);
        end
    end

    // Fetch with a memory responder; delay = cycles of mem_req before mem_ready
    // (0 = mem_ready already high when the request is issued).
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] w, input int delay,
                            output bit got, output logic [31:0] rd, output int cyc,
                            output bit saw_req, output logic [31:0] maddr);
        int wait_cnt;
        got = 0; rd = '0; cyc = 0; saw_req = 0; maddr = '0; wait_cnt = 0;
        @(negedge clock);
        cpu_req = 1'b1; cpu_addr = a; mem_rdata = w;
        if (delay == 0) mem_ready = 1'b1;
        while (!got && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (cpu_ack) begin
                got = 1; rd = cpu_rdata;
            end else if (mem_req) begin
                if (!saw_req) maddr = mem_addr;
                saw_req = 1;
                if (wait_cnt >= delay) mem_ready = 1'b1;
                wait_cnt++;
            end
        end
        cpu_req = 1'b0; mem_ready = 1'b0;
        $display("fetch addr=%h ack=%0d rdata=%h cycles=%0d mem_req=%0d", a, got, rd, cyc, saw_req);
    endtask

    // Pulse flush and wait for flush_done; cyc counts falling edges after the
    // edge that sampled flush.
    task automatic run_flush(output bit done, output int cyc, output int clears,
                             output int order_bad, output int fills);
        int c0, o0, f0;
        c0 = clr_writes; o0 = clr_order_bad; f0 = fill_writes;
        done = 0; cyc = 0;
        @(negedge clock); flush = 1'b1;
        @(negedge clock); flush = 1'b0; cyc = 1;
        while (cyc < 1200) begin
            if (flush_done) begin
                done = 1;
                break;
            end
            @(negedge clock);
            cyc++;
        end
        clears = clr_writes - c0; order_bad = clr_order_bad - o0; fills = fill_writes - f0;
        $display("flush done=%0d cycles=%0d clears=%0d", done, cyc, clears);
    endtask

    task automatic test_reset();
        reset = 1'b1; arr_preset = 1'b1;
        cpu_req = 1'b0; cpu_addr = 32'h0000_0FFC; flush = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clock);
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
        checks++; if (vr_write !== 1'b0) begin errors++; $display("FAIL reset_vr_write: got %b want 0", vr_write); end
        checks++; if (vr_index !== 10'h3FF) begin errors++; $display("FAIL reset_vr_index: got %h want 3ff", vr_index); end
        arr_preset = 1'b0; reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_flush_initial();
        bit done; int cyc, clears, order_bad, fills;
        run_flush(done, cyc, clears, order_bad, fills);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL flush0_done: got %b want 1", done); end
        checks++; if (cyc != 1025) begin errors++; $display("FAIL flush0_cycles: got %0d want 1025", cyc); end
        checks++; if (clears != 1024) begin errors++; $display("FAIL flush0_clears: got %0d want 1024", clears); end
        checks++; if (order_bad != 0) begin errors++; $display("FAIL flush0_order: got %0d want 0", order_bad); end
        checks++; if (fills != 0) begin errors++; $display("FAIL flush0_fills: got %0d want 0", fills); end
        @(negedge clock);
        checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush0_pulse: got %b want 0", flush_done); end
    endtask

    task automatic test_miss_fill();
        bit got, saw; logic [31:0] rd, ma; int cyc;
        do_fetch(32'h0000_1004, 32'hDEAD_BEEF, 2, got, rd, cyc, saw, ma);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL miss_ack: got %b want 1", got); end
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL miss_mem_req: got %b want 1", saw); end
        checks++; if (ma !== 32'h0000_1004) begin errors++; $display("FAIL miss_mem_addr: got %h want 00001004", ma); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_rdata: got %h want deadbeef", rd); end
        @(negedge clock);
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL miss_ack_pulse: got %b want 0", cpu_ack); end
    endtask

    task automatic test_hit();
        bit got, saw; logic [31:0] rd, ma; int cyc;
        do_fetch(32'h0000_1004, 32'h0000_0000, 2, got, rd, cyc, saw, ma);
        checks++; if (cyc != 2) begin errors++; $display("FAIL hit_latency: got %0d want 2", cyc); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_rdata: got %h want deadbeef", rd); end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL hit_mem_req: got %b want 0", saw); end
    endtask

    task automatic test_evict();
        bit got, saw; logic [31:0] rd, ma; int cyc;
        do_fetch(32'h0000_2004, 32'h1234_5678, 1, got, rd, cyc, saw, ma);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL evict_miss: got %b want 1", saw); end
        checks++; if (ma !== 32'h0000_2004) begin errors++; $display("FAIL evict_mem_addr: got %h want 00002004", ma); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL evict_rdata: got %h want 12345678", rd); end
        do_fetch(32'h0000_2004, 32'h0000_0000, 1, got, rd, cyc, saw, ma);
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL evict_rehit: got mem_req %b want 0", saw); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL evict_rehit_rdata: got %h want 12345678", rd); end
        do_fetch(32'h0000_1004, 32'hDEAD_BEEF, 1, got, rd, cyc, saw, ma);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL evict_old_tag_miss: got %b want 1", saw); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL evict_old_rdata: got %h want deadbeef", rd); end
    endtask

    task automatic test_min_miss_latency();
        bit got, saw; logic [31:0] rd, ma; int cyc;
        do_fetch(32'h0000_5008, 32'hA5A5_0F0F, 0, got, rd, cyc, saw, ma);
        checks++; if (cyc != 4) begin errors++; $display("FAIL minmiss_latency: got %0d want 4", cyc); end
        checks++; if (ma !== 32'h0000_5008) begin errors++; $display("FAIL minmiss_mem_addr: got %h want 00005008", ma); end
        checks++; if (rd !== 32'hA5A5_0F0F) begin errors++; $display("FAIL minmiss_rdata: got %h want a5a50f0f", rd); end
    endtask

    task automatic test_back_to_back();
        int cyc, t1, t2; logic [31:0] rd1, rd2;
        cyc = 0; t1 = 99; t2 = 99; rd1 = '0; rd2 = '0;
        @(negedge clock);
        cpu_req = 1'b1; cpu_addr = 32'h0000_1004;
        while (cyc < 20) begin
            @(negedge clock); cyc++;
            if (cpu_ack) begin t1 = cyc; rd1 = cpu_rdata; break; end
        end
        cpu_addr = 32'h0000_5008;   // request stays high across the ack
        while (cyc < 40) begin
            @(negedge clock); cyc++;
            if (cpu_ack) begin t2 = cyc; rd2 = cpu_rdata; break; end
        end
        cpu_req = 1'b0;
        $display("back_to_back t1=%0d rd1=%h t2=%0d rd2=%h", t1, rd1, t2, rd2);
        checks++; if (t1 != 2) begin errors++; $display("FAIL b2b_first_latency: got %0d want 2", t1); end
        checks++; if (rd1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_first_rdata: got %h want deadbeef", rd1); end
        checks++; if (t2 - t1 != 2) begin errors++; $display("FAIL b2b_interval: got %0d want 2", t2 - t1); end
        checks++; if (rd2 !== 32'hA5A5_0F0F) begin errors++; $display("FAIL b2b_second_rdata: got %h want a5a50f0f", rd2); end
    endtask

    task automatic test_flush_index5();
        bit got, saw, done; logic [31:0] rd, ma; int cyc, clears, order_bad, fills;
        do_fetch(32'h0000_3014, 32'h5555_AAAA, 1, got, rd, cyc, saw, ma);
        checks++; if (rd !== 32'h5555_AAAA) begin errors++; $display("FAIL idx5_fill_rdata: got %h want 5555aaaa", rd); end
        do_fetch(32'h0000_3014, 32'h0000_0000, 1, got, rd, cyc, saw, ma);
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL idx5_hit_before_flush: got mem_req %b want 0", saw); end
        run_flush(done, cyc, clears, order_bad, fills);
        checks++; if (cyc != 1025) begin errors++; $display("FAIL idx5_flush_cycles: got %0d want 1025", cyc); end
        checks++; if (clears != 1024) begin errors++; $display("FAIL idx5_flush_clears: got %0d want 1024", clears); end
        checks++; if (order_bad != 0) begin errors++; $display("FAIL idx5_flush_order: got %0d want 0", order_bad); end
        do_fetch(32'h0000_3014, 32'h6666_9999, 1, got, rd, cyc, saw, ma);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL idx5_miss_after_flush: got %b want 1", saw); end
        checks++; if (rd !== 32'h6666_9999) begin errors++; $display("FAIL idx5_refill_rdata: got %h want 66669999", rd); end
    endtask

    task automatic test_flush_during_miss();
        bit got, saw, done; logic [31:0] rd, ma; int cyc, c0, f0;
        c0 = clr_writes; f0 = fill_writes; cyc = 0; got = 0; rd = '0; done = 0;
        @(negedge clock);
        cpu_req = 1'b1; cpu_addr = 32'h0000_4008; mem_rdata = 32'hCAFE_F00D;
        while (!mem_req && cyc < 20) begin @(negedge clock); cyc++; end
        flush = 1'b1;
        @(negedge clock); flush = 1'b0;
        repeat (2) @(negedge clock);
        mem_ready = 1'b1;
        @(negedge clock); mem_ready = 1'b0;
        cyc = 0;
        while (cyc < 10) begin
            if (cpu_ack) begin got = 1; rd = cpu_rdata; break; end
            @(negedge clock); cyc++;
        end
        cpu_addr = 32'h0000_1004;   // new request pending while flush is owed
        @(negedge clock);
        $display("flush_in_miss ack=%0d rdata=%h vr_write=%b vr_v_in=%b vr_index=%h", got, rd, vr_write, vr_v_in, vr_index);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL fim_ack: got %b want 1", got); end
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL fim_rdata: got %h want cafef00d", rd); end
        checks++; if ({vr_write, vr_v_in, vr_index} !== {1'b1, 1'b0, 10'h000}) begin
            errors++; $display("FAIL fim_flush_first: got write=%b v=%b idx=%h want 1 0 000", vr_write, vr_v_in, vr_index);
        end
        cpu_req = 1'b0;
        cyc = 0;
        while (cyc < 1100) begin
            if (flush_done) begin done = 1; break; end
            @(negedge clock); cyc++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL fim_flush_done: got %b want 1", done); end
        checks++; if (clr_writes - c0 != 1024) begin errors++; $display("FAIL fim_clears: got %0d want 1024", clr_writes - c0); end
        checks++; if (fill_writes - f0 != 1) begin errors++; $display("FAIL fim_fills: got %0d want 1", fill_writes - f0); end
        do_fetch(32'h0000_4008, 32'h7777_1111, 1, got, rd, cyc, saw, ma);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL fim_line_flushed: got %b want 1", saw); end
    endtask

    task automatic test_reset_during_miss();
        bit got, saw; logic [31:0] rd, ma; int cyc, a0, f0;
        cyc = 0;
        @(negedge clock);
        cpu_req = 1'b1; cpu_addr = 32'h0000_6010; mem_rdata = 32'hBBBB_BBBB;
        while (!mem_req && cyc < 20) begin @(negedge clock); cyc++; end
        @(negedge clock);
        #2 reset = 1'b1; cpu_req = 1'b0; cpu_addr = 32'h0000_0FFC;
        #1;
        $display("reset_in_miss mem_req=%b cpu_ack=%b vr_index=%h", mem_req, cpu_ack, vr_index);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rim_mem_req: got %b want 0", mem_req); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rim_cpu_ack: got %b want 0", cpu_ack); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rim_mem_addr: got %h want 0", mem_addr); end
        checks++; if (vr_index !== 10'h3FF) begin errors++; $display("FAIL rim_idle_index: got %h want 3ff", vr_index); end
        @(negedge clock); reset = 1'b0;
        a0 = ack_count; f0 = fill_writes;
        mem_ready = 1'b1;
        repeat (3) @(negedge clock);
        mem_ready = 1'b0;
        @(negedge clock);
        checks++; if (ack_count != a0) begin errors++; $display("FAIL rim_late_ack: got %0d want 0", ack_count - a0); end
        checks++; if (fill_writes != f0) begin errors++; $display("FAIL rim_late_write: got %0d want 0", fill_writes - f0); end
        do_fetch(32'h0000_6010, 32'h0102_0304, 1, got, rd, cyc, saw, ma);
        checks++; if (saw !== 1'b1) begin errors++; $display("FAIL rim_refetch_miss: got %b want 1", saw); end
        checks++; if (rd !== 32'h0102_0304) begin errors++; $display("FAIL rim_refetch_rdata: got %h want 01020304", rd); end
    endtask

    initial begin
        test_reset();
        test_flush_initial();
        test_miss_fill();
        test_hit();
        test_evict();
        test_min_miss_latency();
        test_back_to_back();
        test_flush_index5();
        test_flush_during_miss();
        test_reset_during_miss();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
